// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer
// Receive front end for the serial debug unit: oversamples the asynchronous
// rxd line, de-frames 8N1 bytes LSB first and offers each byte on a
// valid/ready handshake with a one-byte holding buffer.
// Optional build macro UART_RX_PARITY_EN switches the framing to 8E1:
// it adds a PARITY state and an active parity_err pulse.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | line idle, waiting for rx_s low (start edge, defines t0)
// START  | waiting for mid start bit to confirm it is not a glitch
// DATA   | sampling data bits 0..7 at mid-bit, LSB first
// PARITY | sampling the even parity bit (UART_RX_PARITY_EN builds only)
// STOP   | sampling the stop bit; frame completes on that edge
`timescale 1ns/1ps
module uart_rx_deframer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rxd,
  output logic [7:0] dout,
  output logic       dout_vld,
  input  logic       dout_rdy,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  // Counter values reached on the cycle before each sample edge.
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;
`endif

  logic          rx_meta;
  logic          rx_s;
  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [2:0]    bit_cnt;
  logic [2:0]    bit_cnt_nxt;
  logic [7:0]    shift;
  logic [7:0]    shift_nxt;
  logic          frame_done;
  logic          bad_par;
  logic          load;
  logic          set_fe;
  logic          set_oe;
  logic          set_pe;

  // Two-flop synchroniser; resets to the idle line level so reset release
  // never looks like a start edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rx_s    <= rx_meta;
    end
  end

  // Frame state, bit-timing counter, bit index and data shift register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
      shift   <= shift_nxt;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  logic par_bit_nxt;

  // Captured parity bit, held until the stop sample decides the frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      par_bit <= 1'b0;
    end else begin
      par_bit <= par_bit_nxt;
    end
  end

  // Even parity: data bits plus parity bit must XOR to zero.
  assign bad_par = ^{shift, par_bit};
`else
  assign bad_par = 1'b0;
`endif

  // Next-state logic; the cycle counter reloads to 0 at every sample point
  // so each sample lands exactly one bit period after the previous one.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + 1'b1;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    frame_done  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_nxt = par_bit;
`endif
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!rx_s) begin
          state_nxt   = START;
          bit_cnt_nxt = '0;
        end
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_nxt   = '0;
          // Line back high at mid start bit: treat as noise, no error.
          state_nxt = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == CNT_BIT) begin
          cnt_nxt            = '0;
          shift_nxt[bit_cnt] = rx_s;
          bit_cnt_nxt        = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == CNT_BIT) begin
          cnt_nxt     = '0;
          par_bit_nxt = rx_s;
          state_nxt   = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt == CNT_BIT) begin
          cnt_nxt    = '0;
          frame_done = 1'b1;
          // Back to IDLE at mid stop bit so a following start edge is
          // caught even with no idle gap between frames.
          state_nxt  = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Frame outcome at the stop sample, one outcome per frame with
  // precedence parity error > framing error > overrun > load.
  always_comb begin
    load   = 1'b0;
    set_fe = 1'b0;
    set_oe = 1'b0;
    set_pe = 1'b0;
    if (frame_done) begin
      if (bad_par) begin
        set_pe = 1'b1;
      end else if (!rx_s) begin
        set_fe = 1'b1;
      end else if (dout_vld && !dout_rdy) begin
        set_oe = 1'b1;
      end else begin
        load = 1'b1;
      end
    end
  end

  // Holding buffer and handshake; a load on the same edge as a consume
  // keeps dout_vld high with the new byte.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dout      <= '0;
      dout_vld  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= set_fe;
      overrun   <= set_oe;
      if (load) begin
        dout     <= shift;
        dout_vld <= 1'b1;
      end else if (dout_vld && dout_rdy) begin
        dout_vld <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity error pulse, registered like the other error flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= set_pe;
    end
  end
`else
  assign parity_err = set_pe;
`endif

  assign busy = (state != IDLE);

endmodule
